// File: rtl/flash_page_buffer_programmer_if.sv
// Flash array request/acknowledge bus.
//   flash_addr        word address presented to the flash array
//   flash_wdata       write data for a word-program request
//   flash_we          word-program request, held until flash_ack
//   flash_erase_page  page-erase request, held until flash_ack
//   flash_ack         one-cycle completion pulse from the flash array
// master: the programmer (drives requests); slave: the flash array.
interface flash_page_buffer_programmer_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] flash_addr;
  logic [DATA_W-1:0] flash_wdata;
  logic              flash_we;
  logic              flash_erase_page;
  logic              flash_ack;

  modport master (
    output flash_addr, flash_wdata, flash_we, flash_erase_page,
    input  flash_ack
  );

  modport slave (
    input  flash_addr, flash_wdata, flash_we, flash_erase_page,
    output flash_ack
  );
endinterface

// File: rtl/flash_page_buffer_programmer.sv
// Page buffer and flash sequencer for parallel programming mode.
// Address and data bytes strobed in by the programming control FSM are
// collected into a PAGE_WORDS-entry buffer; Erase erases the addressed page,
// Prog writes every loaded word of the buffer to the page in index order.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   DATA, BS1             byte bus and byte select (0 = low, 1 = high)
//   EnAdrLat, EnBuf       address-latch / buffer-load strobes (level, edge used)
//   Erase, Prog           page-erase / page-program requests (level, edge used)
//   flash                 flash array request/ack bus (master side)
//   busy                  sequence in progress
//   page_done             one-cycle pulse at the end of a program sequence
//   err_timeout           sticky: flash_ack missing for TIMEOUT_CYC cycles
module flash_page_buffer_programmer #(
  parameter int PAGE_WORDS  = 64,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] DATA,
  input  logic       BS1,
  input  logic       EnAdrLat,
  input  logic       EnBuf,
  input  logic       Erase,
  input  logic       Prog,
  flash_page_buffer_programmer_if.master flash,
  output logic       busy,
  output logic       page_done,
  output logic       err_timeout
);
  localparam int IDX_W = $clog2(PAGE_WORDS);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int HI_W  = ADDR_W - 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE_REQ, S_ERASE_WAIT, S_SCAN, S_WR_REQ, S_WR_WAIT, S_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    prog_pending_reg, pending_next;
  logic                    err_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic [7:0]              low_latch_reg;
  logic [PAGE_WORDS-1:0]   valid_reg;
  logic [DATA_W-1:0]       wdata_reg;
  logic [DATA_W-1:0]       buf_mem [PAGE_WORDS];

  logic [3:0] strobe_cur_reg, strobe_prev_reg, strobe_rise;
  logic       adr_rise, buf_rise, erase_rise, prog_rise;
  logic       adr_wr, low_wr, buf_wr;
  logic       valid_clr, err_set, load_wdata, timed_out, idx_last;
  logic [ADDR_W-IDX_W-1:0] page_hi;

  // Strobes are sampled once, then edge-detected against the previous sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_cur_reg  <= '0;
      strobe_prev_reg <= '0;
    end else begin
      strobe_cur_reg  <= {Prog, Erase, EnBuf, EnAdrLat};
      strobe_prev_reg <= strobe_cur_reg;
    end
  end

  assign strobe_rise = strobe_cur_reg & ~strobe_prev_reg;
  assign adr_rise    = strobe_rise[0];
  assign buf_rise    = strobe_rise[1];
  assign erase_rise  = strobe_rise[2];
  assign prog_rise   = strobe_rise[3];

  // Buffer loading is frozen while a sequence runs.
  assign adr_wr = adr_rise & ~busy & ~BS1 | adr_rise & ~busy & BS1;
  assign low_wr = buf_rise & ~busy & ~BS1;
  assign buf_wr = buf_rise & ~busy & BS1;

  assign page_hi   = addr_reg[ADDR_W-1:IDX_W];
  assign timed_out = (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
  assign idx_last  = (idx_reg == IDX_W'(PAGE_WORDS - 1));
  assign err_timeout = err_reg;

  always_comb begin
    state_next             = state_reg;
    idx_next               = idx_reg;
    cnt_next               = cnt_reg + 1'b1;
    pending_next           = prog_pending_reg;
    valid_clr              = 1'b0;
    err_set                = 1'b0;
    load_wdata             = 1'b0;
    busy                   = (state_reg != S_IDLE);
    page_done              = 1'b0;
    flash.flash_we         = 1'b0;
    flash.flash_erase_page = 1'b0;
    flash.flash_addr       = '0;
    flash.flash_wdata      = '0;

    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (erase_rise) begin
          state_next   = S_ERASE_REQ;
          pending_next = prog_rise;
        end else if (prog_rise) begin
          state_next = S_SCAN;
          idx_next   = '0;
        end
      end
      S_ERASE_REQ, S_ERASE_WAIT: begin
        flash.flash_erase_page = 1'b1;
        flash.flash_addr       = {page_hi, {IDX_W{1'b0}}};
        pending_next           = prog_pending_reg | prog_rise;
        // ack is only honoured once the request has been seen for a cycle
        if (state_reg == S_ERASE_WAIT && flash.flash_ack) begin
          if (prog_pending_reg | prog_rise) begin
            state_next = S_SCAN;
            idx_next   = '0;
          end else begin
            state_next = S_IDLE;
          end
          pending_next = 1'b0;
        end else if (timed_out) begin
          state_next   = S_IDLE;
          err_set      = 1'b1;
          valid_clr    = 1'b1;
          pending_next = 1'b0;
        end else begin
          state_next = S_ERASE_WAIT;
        end
      end
      S_SCAN: begin
        if (valid_reg[idx_reg]) begin
          state_next = S_WR_REQ;
          load_wdata = 1'b1;
          cnt_next   = '0;
        end else if (idx_last) begin
          state_next = S_DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      S_WR_REQ, S_WR_WAIT: begin
        flash.flash_we    = 1'b1;
        flash.flash_addr  = {page_hi, idx_reg};
        flash.flash_wdata = wdata_reg;
        if (state_reg == S_WR_WAIT && flash.flash_ack) begin
          // the last index finishes the page directly; rescanning from a
          // wrapped index would revisit words that are still marked valid
          if (idx_last) begin
            state_next = S_DONE;
          end else begin
            state_next = S_SCAN;
            idx_next   = idx_reg + 1'b1;
          end
        end else if (timed_out) begin
          state_next   = S_IDLE;
          err_set      = 1'b1;
          valid_clr    = 1'b1;
          pending_next = 1'b0;
        end else begin
          state_next = S_WR_WAIT;
        end
      end
      S_DONE: begin
        page_done  = 1'b1;
        valid_clr  = 1'b1;
        idx_next   = '0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      idx_reg          <= '0;
      cnt_reg          <= '0;
      prog_pending_reg <= 1'b0;
      err_reg          <= 1'b0;
      addr_reg         <= '0;
      low_latch_reg    <= '0;
      valid_reg        <= '0;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      cnt_reg          <= cnt_next;
      prog_pending_reg <= pending_next;
      if (err_set) err_reg <= 1'b1;
      if (adr_wr) begin
        if (!BS1) addr_reg[7:0]        <= DATA;
        else      addr_reg[ADDR_W-1:8] <= DATA[HI_W-1:0];
      end
      if (low_wr) low_latch_reg <= DATA;
      if (valid_clr)   valid_reg <= '0;
      else if (buf_wr) valid_reg[addr_reg[IDX_W-1:0]] <= 1'b1;
    end
  end

  // Buffer storage: unreset RAM with a registered read feeding write data.
  always_ff @(posedge clk) begin
    if (buf_wr) buf_mem[addr_reg[IDX_W-1:0]] <= {DATA, low_latch_reg};
    if (load_wdata) wdata_reg <= buf_mem[idx_reg];
  end
endmodule

// File: tb/tb_flash_page_buffer_programmer.sv
// Randomized bench: a page-level model (buffer array, valid flags, address)
// predicts the ordered flash transactions and page_done count of each
// operation; a negedge monitor checks the DUT against it every cycle.
module tb_flash_page_buffer_programmer;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       bs1 = 1'b0, en_adr = 1'b0, en_buf = 1'b0, erase = 1'b0, prog = 1'b0;
  logic       busy, page_done, err_timeout;

  flash_page_buffer_programmer_if #(.ADDR_W(14), .DATA_W(16)) fif ();

  flash_page_buffer_programmer #(
    .PAGE_WORDS(64), .ADDR_W(14), .DATA_W(16), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .DATA(data), .BS1(bs1),
    .EnAdrLat(en_adr), .EnBuf(en_buf), .Erase(erase), .Prog(prog),
    .flash(fif), .busy(busy), .page_done(page_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_erase;
    logic [13:0] addr;
    logic [15:0] data;
  } txn_t;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model
  logic [15:0] m_buf [64];
  bit          m_valid [64];
  logic [13:0] m_addr = '0;
  logic [7:0]  m_low = '0;
  txn_t        exp_q [$];
  txn_t        txn_log [$];
  int          exp_done = 0;
  int          done_cnt = 0;

  // flash responder controls
  int ack_delay = 2;
  bit ack_en = 1'b1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic txn_t mk(logic e, logic [13:0] a, logic [15:0] d);
    txn_t t;
    t.is_erase = e;
    t.addr = a;
    t.data = d;
    return t;
  endfunction

  // Flash array: acks a held request ack_delay negedges after first seeing it.
  initial begin
    int  rcnt;
    bit  racked;
    rcnt = 0;
    racked = 1'b0;
    fif.flash_ack = 1'b0;
    forever begin
      @(negedge clk);
      fif.flash_ack = 1'b0;
      if (fif.flash_we || fif.flash_erase_page) begin
        if (ack_en && !racked) begin
          rcnt++;
          if (rcnt >= ack_delay) begin
            fif.flash_ack = 1'b1;
            racked = 1'b1;
          end
        end
      end else begin
        rcnt = 0;
        racked = 1'b0;
      end
    end
  end

  // Compare process.
  logic        p_we = 1'b0, p_er = 1'b0;
  logic [13:0] h_addr = '0;
  logic [15:0] h_data = '0;
  txn_t        act_t, exp_t;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_we = 1'b0;
      p_er = 1'b0;
    end else begin
      if (fif.flash_we || fif.flash_erase_page) begin
        check("req_exclusive", 32'(fif.flash_we & fif.flash_erase_page), 32'd0);
        check("busy_during_req", 32'(busy), 32'd1);
      end
      if ((fif.flash_we && !p_we) || (fif.flash_erase_page && !p_er)) begin
        act_t = mk(fif.flash_erase_page, fif.flash_addr,
                   fif.flash_we ? fif.flash_wdata : 16'h0000);
        txn_log.push_back(act_t);
        $display("txn %s addr=0x%04h data=0x%04h t=%0t",
                 act_t.is_erase ? "erase" : "write", act_t.addr, act_t.data, $time);
        check("txn_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t = exp_q.pop_front();
          check("txn_kind", 32'(act_t.is_erase), 32'(exp_t.is_erase));
          check("txn_addr", 32'(act_t.addr), 32'(exp_t.addr));
          check("txn_wdata", 32'(act_t.data), 32'(exp_t.data));
        end
        h_addr = fif.flash_addr;
        h_data = fif.flash_wdata;
      end else if ((fif.flash_we && p_we) || (fif.flash_erase_page && p_er)) begin
        check("req_addr_stable", 32'(fif.flash_addr), 32'(h_addr));
        check("req_wdata_stable", 32'(fif.flash_wdata), 32'(h_data));
      end
      if (page_done) begin
        done_cnt++;
        check("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
      end
      p_we = fif.flash_we;
      p_er = fif.flash_erase_page;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe_adr(input bit hi, input logic [7:0] d);
    data = d; bs1 = hi; en_adr = 1'b1;
    tick(2);
    en_adr = 1'b0;
    tick(2);
    if (!hi) m_addr[7:0] = d;
    else     m_addr[13:8] = d[5:0];
  endtask

  task automatic strobe_buf(input bit hi, input logic [7:0] d);
    data = d; bs1 = hi; en_buf = 1'b1;
    tick(2);
    en_buf = 1'b0;
    tick(2);
    if (!hi) m_low = d;
    else begin
      m_buf[m_addr[5:0]] = {d, m_low};
      m_valid[m_addr[5:0]] = 1'b1;
    end
  endtask

  task automatic set_page(input logic [13:0] a);
    strobe_adr(1'b1, {2'b00, a[13:8]});
    strobe_adr(1'b0, a[7:0]);
  endtask

  task automatic load_word(input logic [5:0] idx, input logic [15:0] v);
    strobe_adr(1'b0, {m_addr[7:6], idx});
    strobe_buf(1'b0, v[7:0]);
    strobe_buf(1'b1, v[15:8]);
  endtask

  // kind: 0 prog, 1 erase+prog same cycle, 2 erase only, 3 prog during erase
  task automatic start_op(input int kind, input bit expect_done);
    logic [13:0] base;
    base = {m_addr[13:6], 6'b0};
    if (kind != 0) exp_q.push_back(mk(1'b1, base, 16'h0000));
    if (kind != 2) begin
      for (int i = 0; i < 64; i++) begin
        if (m_valid[i]) begin
          exp_q.push_back(mk(1'b0, {m_addr[13:6], 6'(i)}, m_buf[i]));
          m_valid[i] = 1'b0;
        end
      end
      if (expect_done) exp_done++;
    end
    txn_log.delete();
    case (kind)
      0: begin prog = 1'b1; tick(2); prog = 1'b0; end
      1: begin erase = 1'b1; prog = 1'b1; tick(2); erase = 1'b0; prog = 1'b0; end
      2: begin erase = 1'b1; tick(2); erase = 1'b0; end
      default: begin
        erase = 1'b1; tick(1); prog = 1'b1; tick(1); erase = 1'b0; tick(1); prog = 1'b0;
      end
    endcase
  endtask

  task automatic finish_op();
    int n;
    tick(3);
    n = 0;
    while (busy && n < 3000) begin
      tick(1);
      n++;
    end
    check("idle_within_budget", 32'(busy), 32'd0);
    check("page_done_count", 32'(done_cnt), 32'(exp_done));
    check("all_txns_seen", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_we();
    int n;
    n = 0;
    while (!fif.flash_we && n < 200) begin
      tick(1);
      n++;
    end
    check("we_within_budget", 32'(fif.flash_we), 32'd1);
  endtask

  initial begin
    int  cyc;
    bit  all_busy;
    bit  found;
    for (int i = 0; i < 64; i++) begin
      m_buf[i] = '0;
      m_valid[i] = 1'b0;
    end

    // reset state
    tick(3);
    check("rst_flash_we", 32'(fif.flash_we), 32'd0);
    check("rst_flash_erase", 32'(fif.flash_erase_page), 32'd0);
    check("rst_flash_addr", 32'(fif.flash_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_page_done", 32'(page_done), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: single word at 0x0140
    set_page(14'h0140);
    load_word(6'd0, 16'h1234);
    start_op(0, 1'b1);
    finish_op();
    check("t1_write_count", 32'(txn_log.size()), 32'd1);
    if (txn_log.size() >= 1) begin
      check("t1_addr", 32'(txn_log[0].addr), 32'h0140);
      check("t1_wdata", 32'(txn_log[0].data), 32'h1234);
    end

    // 2: empty buffer (valid cleared by 1), page_done 65 cycles after Prog edge
    txn_log.delete();
    exp_done++;
    prog = 1'b1;
    @(posedge clk);
    cyc = 0; all_busy = 1'b1; found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) prog = 1'b0;
      if (!busy) all_busy = 1'b0;
      if (page_done) found = 1'b1;
    end
    check("t2_done_latency", 32'(cyc), 32'd65);
    check("t2_busy_throughout", 32'(all_busy), 32'd1);
    finish_op();
    check("t2_no_writes", 32'(txn_log.size()), 32'd0);

    // 3: erase and prog together at 0x3FC0
    set_page(14'h3FC0);
    load_word(6'd5, 16'hA5A5);
    load_word(6'd63, 16'hBEEF);
    start_op(1, 1'b1);
    finish_op();
    check("t3_txn_count", 32'(txn_log.size()), 32'd3);
    if (txn_log.size() >= 3) begin
      check("t3_first_is_erase", 32'(txn_log[0].is_erase), 32'd1);
      check("t3_erase_addr", 32'(txn_log[0].addr), 32'h3FC0);
      check("t3_w0_addr", 32'(txn_log[1].addr), 32'h3FC5);
      check("t3_w0_data", 32'(txn_log[1].data), 32'hA5A5);
      check("t3_w1_addr", 32'(txn_log[2].addr), 32'h3FFF);
      check("t3_w1_data", 32'(txn_log[2].data), 32'hBEEF);
    end

    // 4: full page, data = idx, ack delay 3
    ack_delay = 3;
    set_page(14'h1A80);
    for (int i = 0; i < 64; i++) load_word(6'(i), 16'(i));
    start_op(0, 1'b1);
    finish_op();
    check("t4_write_count", 32'(txn_log.size()), 32'd64);
    for (int i = 0; i < 64 && i < txn_log.size(); i++) begin
      check("t4_order_addr", 32'(txn_log[i].addr), 32'h1A80 + 32'(i));
      check("t4_order_data", 32'(txn_log[i].data), 32'(i));
    end

    // randomized rounds
    for (int r = 0; r < 16; r++) begin
      int n;
      int kind;
      ack_delay = int'($urandom_range(2, 5));
      if ($urandom_range(0, 1) == 1) set_page(14'($urandom));
      n = int'($urandom_range(0, 8));
      for (int w = 0; w < n; w++) load_word(6'($urandom_range(0, 63)), 16'($urandom));
      kind = int'($urandom_range(0, 3));
      start_op(kind, 1'b1);
      finish_op();
    end

    // 5: timeout with ack withheld
    ack_en = 1'b0;
    set_page(14'h2200);
    load_word(6'd7, 16'h5A5A);
    start_op(0, 1'b0);
    wait_we();
    cyc = 0;
    while (fif.flash_we && cyc < 100) begin
      cyc++;
      tick(1);
    end
    check("t5_req_cycles", 32'(cyc), 32'(TO));
    check("t5_err_set", 32'(err_timeout), 32'd1);
    check("t5_we_low", 32'(fif.flash_we), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);
    ack_en = 1'b1;
    start_op(0, 1'b1);
    finish_op();
    check("t5_valid_cleared", 32'(txn_log.size()), 32'd0);
    check("t5_err_sticky", 32'(err_timeout), 32'd1);

    // 6: reset during WR_WAIT
    ack_en = 1'b0;
    load_word(6'd1, 16'h1111);
    load_word(6'd2, 16'h2222);
    start_op(0, 1'b0);
    wait_we();
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_we_async_drop", 32'(fif.flash_we), 32'd0);
    check("t6_busy_async_drop", 32'(busy), 32'd0);
    check("t6_err_cleared", 32'(err_timeout), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_addr = '0;
    m_low = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    ack_en = 1'b1;
    tick(2);
    start_op(0, 1'b1);
    finish_op();
    check("t6_valid_cleared", 32'(txn_log.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
